// File: rtl/odesa_pkg.sv
`default_nettype none
// ============================================================
// Package : odesa_pkg
// Purpose : shared defaults and width helpers for the ODESA layer
// Revision: 1.0
// ============================================================
package odesa_pkg;

  localparam int c_n_in_def    = 2;
  localparam int c_n_neur_def  = 4;
  localparam int c_p_width_def = 9;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Full-precision width of a sum of N_IN products of two P_WIDTH operands
  function automatic int pot_w(input int p_width, input int n_in);
    return 2 * p_width + clog2(n_in);
  endfunction

  function automatic int thr_w(input int p_width, input int n_in, input int thr_init);
    int b;
    int p;
    b = clog2(thr_init + 1);
    p = pot_w(p_width, n_in);
    return (b > p) ? b : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/odesa_layer_n_if.sv
`default_nettype none
// ============================================================
// Interface: odesa_layer_n_if
// Purpose  : event/label inputs and spike/attention outputs of the layer
// Revision : 1.0
// ============================================================
interface odesa_layer_n_if
  import odesa_pkg::*;
#(
  parameter int N_IN   = c_n_in_def,
  parameter int N_NEUR = c_n_neur_def,
  parameter int TS_W   = 18
);

  logic [N_IN-1:0]   i_event;
  logic [N_NEUR-1:0] i_label;
  logic              i_train_en;
  logic              i_endof_epochs;
  logic [TS_W-1:0]   o_tr;
  logic [N_NEUR-1:0] o_spike_out;
  logic              o_las;
  logic              o_gas;
  logic              o_learn_done;
  logic              o_busy;

  modport master (
    output i_event, i_label, i_train_en, i_endof_epochs,
    input  o_tr, o_spike_out, o_las, o_gas, o_learn_done, o_busy
  );

  modport slave (
    input  i_event, i_label, i_train_en, i_endof_epochs,
    output o_tr, o_spike_out, o_las, o_gas, o_learn_done, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/odesa_wta.sv
`default_nettype none
// ============================================================
// Module  : odesa_wta
// Purpose : thresholded argmax over neuron potentials, lowest index wins ties
// Revision: 1.0
// ============================================================
module odesa_wta
  import odesa_pkg::*;
#(
  parameter int N_NEUR = c_n_neur_def,
  parameter int POT_W  = 19,
  parameter int THR_W  = 19
) (
  input  logic [N_NEUR-1:0][POT_W-1:0] i_pot,
  input  logic [N_NEUR-1:0][THR_W-1:0] i_thr,
  output logic [N_NEUR-1:0]            o_winner,
  output logic                         o_found
);

  localparam int c_cmp_w = (POT_W > THR_W) ? POT_W : THR_W;

  logic [c_cmp_w-1:0] w_best;

  // Strict greater-than keeps the earliest index on equal potentials
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_best   = '0;
    for (int j = 0; j < N_NEUR; j++) begin
      if ((c_cmp_w'(i_pot[j]) >= c_cmp_w'(i_thr[j])) &&
          (!o_found || (c_cmp_w'(i_pot[j]) > w_best))) begin
        o_found     = 1'b1;
        w_best      = c_cmp_w'(i_pot[j]);
        o_winner    = '0;
        o_winner[j] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/odesa_layer_n.sv
`default_nettype none
// ============================================================
// Module  : odesa_layer_n
// Purpose : time-surface layer, WTA and label-supervised online training
// Revision: 1.0
// ============================================================
module odesa_layer_n
  import odesa_pkg::*;
#(
  parameter int N_IN     = c_n_in_def,
  parameter int N_NEUR   = c_n_neur_def,
  parameter int P_WIDTH  = c_p_width_def,
  parameter int TS_W     = 18,
  parameter int TAU      = 511,
  parameter int ETA_SH   = 3,
  parameter int THR_DEC  = 16,
  parameter int W_INIT   = 256,
  parameter int THR_INIT = 65536
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  odesa_layer_n_if.slave bus
);

  localparam int c_pot_w = pot_w(P_WIDTH, N_IN);
  localparam int c_thr_w = thr_w(P_WIDTH, N_IN, THR_INIT);

  logic [TS_W-1:0]                         r_tr;
  logic [N_IN-1:0][P_WIDTH-1:0]            r_age;
  logic [N_IN-1:0][P_WIDTH-1:0]            w_trace;
  logic [N_NEUR-1:0][N_IN-1:0][P_WIDTH-1:0] r_w;
  logic [N_NEUR-1:0][N_IN-1:0][P_WIDTH-1:0] w_w_nxt;
  logic [N_NEUR-1:0][c_thr_w-1:0]          r_thr;
  logic [N_NEUR-1:0][c_thr_w-1:0]          w_thr_nxt;
  logic [N_NEUR-1:0][c_pot_w-1:0]          w_pot;

  logic                                    r_s1_vld;
  logic                                    r_s1_train;
  logic [N_NEUR-1:0]                       r_s1_label;

  logic                                    r_s2_vld;
  logic                                    r_s2_train;
  logic [N_NEUR-1:0]                       r_s2_label;
  logic [N_NEUR-1:0][c_pot_w-1:0]          r_s2_pot;
  logic [N_IN-1:0][P_WIDTH-1:0]            r_s2_trace;

  logic                                    r_s3_vld;
  logic                                    r_s3_train;
  logic [N_NEUR-1:0]                       r_s3_label;
  logic [N_NEUR-1:0]                       r_s3_win;
  logic [N_NEUR-1:0][c_pot_w-1:0]          r_s3_pot;
  logic [N_IN-1:0][P_WIDTH-1:0]            r_s3_trace;

  logic [N_NEUR-1:0]                       w_win;
  logic                                    w_found;
  logic [N_NEUR-1:0]                       w_target;
  logic                                    w_learn;
  logic                                    w_hit;

  logic [N_NEUR-1:0]                       r_spike;
  logic                                    r_las;
  logic                                    r_gas;
  logic                                    r_learn_done;

  // The result always lies between the old weight and the trace; clamp is a guard
  function automatic logic [P_WIDTH-1:0] f_upd_w(input logic [P_WIDTH-1:0] w,
                                                 input logic [P_WIDTH-1:0] t);
    logic signed [P_WIDTH+1:0] d;
    logic signed [P_WIDTH+1:0] s;
    d = $signed({2'b00, t}) - $signed({2'b00, w});
    s = $signed({2'b00, w}) + (d >>> ETA_SH);
    if (s[P_WIDTH+1])    return '0;
    else if (s[P_WIDTH]) return '1;
    else                 return s[P_WIDTH-1:0];
  endfunction

  function automatic logic [c_thr_w-1:0] f_upd_thr(input logic [c_thr_w-1:0] thr,
                                                   input logic [c_pot_w-1:0] pot);
    logic signed [c_thr_w+1:0] d;
    logic signed [c_thr_w+1:0] s;
    d = $signed({2'b00, c_thr_w'(pot)}) - $signed({2'b00, thr});
    s = $signed({2'b00, thr}) + (d >>> ETA_SH);
    if (s[c_thr_w+1])    return '0;
    else if (s[c_thr_w]) return '1;
    else                 return s[c_thr_w-1:0];
  endfunction

  always_comb begin
    w_trace = '0;
    for (int i = 0; i < N_IN; i++) w_trace[i] = P_WIDTH'(TAU) - r_age[i];
  end

  always_comb begin
    w_pot = '0;
    for (int j = 0; j < N_NEUR; j++)
      for (int i = 0; i < N_IN; i++)
        w_pot[j] = w_pot[j] + c_pot_w'(r_w[j][i]) * c_pot_w'(w_trace[i]);
  end

  odesa_wta #(
    .N_NEUR (N_NEUR),
    .POT_W  (c_pot_w),
    .THR_W  (c_thr_w)
  ) u_wta (
    .i_pot    (r_s2_pot),
    .i_thr    (r_thr),
    .o_winner (w_win),
    .o_found  (w_found)
  );

  // Isolating the lowest set bit makes a multi-hot label target its lowest neuron
  assign w_target = r_s3_label & (~r_s3_label + N_NEUR'(1));
  assign w_learn  = r_s3_vld & (|r_s3_label) & r_s3_train & ~r_learn_done;
  assign w_hit    = |(w_target & r_s3_win);

  always_comb begin
    w_w_nxt   = r_w;
    w_thr_nxt = r_thr;
    for (int j = 0; j < N_NEUR; j++) begin
      if (w_learn && w_target[j]) begin
        if (w_hit) begin
          for (int i = 0; i < N_IN; i++) w_w_nxt[j][i] = f_upd_w(r_w[j][i], r_s3_trace[i]);
          w_thr_nxt[j] = f_upd_thr(r_thr[j], r_s3_pot[j]);
        end else if (r_thr[j] >= c_thr_w'(THR_DEC)) begin
          w_thr_nxt[j] = r_thr[j] - c_thr_w'(THR_DEC);
        end else begin
          w_thr_nxt[j] = '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tr         <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_train   <= 1'b0;
      r_s1_label   <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_train   <= 1'b0;
      r_s2_label   <= '0;
      r_s2_pot     <= '0;
      r_s2_trace   <= '0;
      r_s3_vld     <= 1'b0;
      r_s3_train   <= 1'b0;
      r_s3_label   <= '0;
      r_s3_win     <= '0;
      r_s3_pot     <= '0;
      r_s3_trace   <= '0;
      r_spike      <= '0;
      r_las        <= 1'b0;
      r_gas        <= 1'b0;
      r_learn_done <= 1'b0;
      for (int i = 0; i < N_IN; i++) r_age[i] <= P_WIDTH'(TAU);
      for (int j = 0; j < N_NEUR; j++) begin
        r_thr[j] <= c_thr_w'(THR_INIT);
        for (int i = 0; i < N_IN; i++) r_w[j][i] <= P_WIDTH'(W_INIT);
      end
    end else begin
      r_tr <= r_tr + TS_W'(1);
      for (int i = 0; i < N_IN; i++) begin
        if (bus.i_event[i])                 r_age[i] <= '0;
        else if (r_age[i] != P_WIDTH'(TAU)) r_age[i] <= r_age[i] + P_WIDTH'(1);
      end

      r_s1_vld   <= |bus.i_event;
      r_s1_label <= bus.i_label;
      r_s1_train <= bus.i_train_en;

      r_s2_vld   <= r_s1_vld;
      r_s2_label <= r_s1_label;
      r_s2_train <= r_s1_train;
      r_s2_pot   <= w_pot;
      r_s2_trace <= w_trace;

      r_s3_vld   <= r_s2_vld;
      r_s3_label <= r_s2_label;
      r_s3_train <= r_s2_train;
      r_s3_win   <= w_win;
      r_s3_pot   <= r_s2_pot;
      r_s3_trace <= r_s2_trace;

      r_spike <= r_s2_vld ? w_win : '0;
      r_las   <= r_s2_vld & w_found;
      r_gas   <= r_s3_vld & (|r_s3_label);

      r_w   <= w_w_nxt;
      r_thr <= w_thr_nxt;

      if (bus.i_endof_epochs) r_learn_done <= 1'b1;
    end
  end

  assign bus.o_tr         = r_tr;
  assign bus.o_spike_out  = r_spike;
  assign bus.o_las        = r_las;
  assign bus.o_gas        = r_gas;
  assign bus.o_learn_done = r_learn_done;
  assign bus.o_busy       = r_s1_vld | r_s2_vld | r_s3_vld;

endmodule
`default_nettype wire

// File: tb/tb_odesa_layer_n.sv
`default_nettype none
// ============================================================
// Module  : tb_odesa_layer_n
// Purpose : directed bench with an event-level reference model for odesa_layer_n
// Revision: 1.0
// ============================================================
module tb_odesa_layer_n;

  localparam int N_IN     = 2;
  localparam int N_NEUR   = 4;
  localparam int P_WIDTH  = 9;
  localparam int TS_W     = 18;
  localparam int TAU      = 511;
  localparam int ETA_SH   = 3;
  localparam int THR_DEC  = 16;
  localparam int W_INIT   = 256;
  localparam int THR_INIT = 65536;
  localparam int W_MAX    = (1 << P_WIDTH) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  odesa_layer_n_if #(.N_IN(N_IN), .N_NEUR(N_NEUR), .TS_W(TS_W)) bus ();

  odesa_layer_n #(
    .N_IN(N_IN), .N_NEUR(N_NEUR), .P_WIDTH(P_WIDTH), .TS_W(TS_W), .TAU(TAU),
    .ETA_SH(ETA_SH), .THR_DEC(THR_DEC), .W_INIT(W_INIT), .THR_INIT(THR_INIT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_spk  = 0;
  int last_spk = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: every accepted event is a record tagged with edges elapsed
  typedef struct {
    int                      label;
    bit                      train;
    int                      win;
    int                      age;
    logic [N_IN-1:0][31:0]   trace;
    logic [N_NEUR-1:0][31:0] pot;
  } rec_t;

  rec_t q[$];
  int   m_age[N_IN];
  int   m_w[N_NEUR][N_IN];
  int   m_thr[N_NEUR];
  int   m_tr;
  bit   m_done;
  int   e_spike, e_las, e_gas, e_busy;

  function automatic int lowest_bit(input int v);
    for (int j = 0; j < N_NEUR; j++) if (v[j]) return j;
    return -1;
  endfunction

  function automatic int clampw(input int v);
    if (v < 0) return 0;
    if (v > W_MAX) return W_MAX;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N_IN; i++) m_age[i] = TAU;
    for (int j = 0; j < N_NEUR; j++) begin
      m_thr[j] = THR_INIT;
      for (int i = 0; i < N_IN; i++) m_w[j][i] = W_INIT;
    end
    m_tr = 0; m_done = 0;
    e_spike = 0; e_las = 0; e_gas = 0; e_busy = 0;
  endtask

  task automatic model_step();
    int   ns, nl, ng, t, best;
    rec_t r;
    ns = 0; nl = 0; ng = 0;
    foreach (q[k]) q[k].age = q[k].age + 1;
    if (q.size() > 0 && q[0].age == 3) begin
      r = q.pop_front();
      if (r.label != 0) begin
        ng = 1;
        t  = lowest_bit(r.label);
        if (r.train && !m_done) begin
          if (r.win == t) begin
            for (int i = 0; i < N_IN; i++)
              m_w[t][i] = clampw(m_w[t][i] + ((int'(r.trace[i]) - m_w[t][i]) >>> ETA_SH));
            m_thr[t] = m_thr[t] + ((int'(r.pot[t]) - m_thr[t]) >>> ETA_SH);
          end else begin
            m_thr[t] = (m_thr[t] > THR_DEC) ? m_thr[t] - THR_DEC : 0;
          end
        end
      end
    end
    foreach (q[k]) begin
      if (q[k].age == 2) begin
        ns = (q[k].win < 0) ? 0 : (1 << q[k].win);
        nl = (q[k].win >= 0) ? 1 : 0;
      end
      if (q[k].age == 1) begin
        best = -1;
        for (int j = 0; j < N_NEUR; j++)
          if (int'(q[k].pot[j]) >= m_thr[j] && (best < 0 || q[k].pot[j] > q[k].pot[best])) best = j;
        q[k].win = best;
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (bus.i_event[i]) m_age[i] = 0;
      else if (m_age[i] < TAU) m_age[i] = m_age[i] + 1;
    end
    if (bus.i_event != '0) begin
      r.label = int'(bus.i_label);
      r.train = bus.i_train_en;
      r.win   = -1;
      r.age   = 0;
      for (int i = 0; i < N_IN; i++) r.trace[i] = 32'(TAU - m_age[i]);
      for (int j = 0; j < N_NEUR; j++) begin
        r.pot[j] = '0;
        for (int i = 0; i < N_IN; i++) r.pot[j] = r.pot[j] + 32'(m_w[j][i] * (TAU - m_age[i]));
      end
      q.push_back(r);
    end
    m_tr = (m_tr + 1) % (1 << TS_W);
    if (bus.i_endof_epochs) m_done = 1;
    e_spike = ns; e_las = nl; e_gas = ng;
    e_busy  = (q.size() > 0) ? 1 : 0;
  endtask

  // Compare on the falling edge, then advance the model over the coming rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("spike_out",  int'(bus.o_spike_out),  e_spike);
      chk("las",        int'(bus.o_las),        e_las);
      chk("gas",        int'(bus.o_gas),        e_gas);
      chk("learn_done", int'(bus.o_learn_done), int'(m_done));
      chk("busy",       int'(bus.o_busy),       e_busy);
      chk("tr",         int'(bus.o_tr),         m_tr);
      if (bus.o_spike_out != '0) begin
        n_spk++;
        last_spk = int'(bus.o_spike_out);
      end
      if (rst_n) model_step();
    end
  end

  task automatic send(input logic [N_IN-1:0] ev, input logic [N_NEUR-1:0] lab,
                      input logic tr, input logic eoe);
    bus.i_event = ev; bus.i_label = lab; bus.i_train_en = tr; bus.i_endof_epochs = eoe;
    @(posedge clk); #1;
    bus.i_event = '0; bus.i_label = '0; bus.i_train_en = 1'b0; bus.i_endof_epochs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_state(input string tag);
    for (int j = 0; j < N_NEUR; j++) begin
      chk($sformatf("%s thr%0d", tag, j), int'(dut.r_thr[j]), m_thr[j]);
      for (int i = 0; i < N_IN; i++)
        chk($sformatf("%s w%0d_%0d", tag, j, i), int'(dut.r_w[j][i]), m_w[j][i]);
    end
    for (int i = 0; i < N_IN; i++)
      chk($sformatf("%s age%0d", tag, i), int'(dut.r_age[i]), m_age[i]);
  endtask

  initial begin
    bus.i_event = '0; bus.i_label = '0; bus.i_train_en = 1'b0; bus.i_endof_epochs = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Unlabelled event on ch1: every neuron ties at 256*511, neuron 0 wins
    n_spk = 0;
    send(2'b10, 4'b0000, 1'b1, 1'b0);
    idle(1);
    chk("A pot0", int'(dut.r_s2_pot[0]), 130816);
    chk("A pot3", int'(dut.r_s2_pot[3]), 130816);
    idle(4);
    chk("A spikes", n_spk, 1);
    chk("A winner", last_spk, 1);
    chk("A w0_1", int'(dut.r_w[0][1]), 256);
    chk_state("A");

    // Correct label: neuron 0 moves toward the trace
    do_reset();
    send(2'b10, 4'b0001, 1'b1, 1'b0);
    idle(5);
    chk("B w0_1", int'(dut.r_w[0][1]), 287);
    chk("B w0_0", int'(dut.r_w[0][0]), 224);
    chk("B thr0", int'(dut.r_thr[0]), 73696);
    chk("B model w0_1", m_w[0][1], 287);
    chk("B model thr0", m_thr[0], 73696);
    chk_state("B");

    // Wrong winner: neuron 1 threshold drops, weights stay
    do_reset();
    send(2'b10, 4'b0010, 1'b1, 1'b0);
    idle(5);
    chk("C thr1", int'(dut.r_thr[1]), 65520);
    chk("C w1_1", int'(dut.r_w[1][1]), 256);
    chk("C model thr1", m_thr[1], 65520);
    chk_state("C");

    // Ch0 trace has fully decayed by the ch1 event 512 edges later
    do_reset();
    send(2'b01, 4'b0000, 1'b0, 1'b0);
    idle(511);
    send(2'b10, 4'b0000, 1'b0, 1'b0);
    chk("D trace0", TAU - int'(dut.r_age[0]), 0);
    chk("D trace1", TAU - int'(dut.r_age[1]), 511);
    idle(5);
    do_reset();
    n_spk = 0;
    idle(600);
    chk("D idle spikes", n_spk, 0);
    chk("D age0", int'(dut.r_age[0]), TAU);
    chk("D age1", int'(dut.r_age[1]), TAU);
    chk_state("D");

    // Freeze: labelled events still spike and raise gas but change nothing
    do_reset();
    send(2'b00, 4'b0000, 1'b0, 1'b1);
    chk("E done", int'(bus.o_learn_done), 1);
    n_spk = 0;
    send(2'b10, 4'b0001, 1'b1, 1'b0);
    idle(3);
    send(2'b01, 4'b0010, 1'b1, 1'b0);
    idle(6);
    chk("E spikes", n_spk, 2);
    chk("E w0_1", int'(dut.r_w[0][1]), 256);
    chk("E thr0", int'(dut.r_thr[0]), 65536);
    chk("E thr1", int'(dut.r_thr[1]), 65536);
    chk("E done hold", int'(bus.o_learn_done), 1);
    chk_state("E");

    // Back-to-back events, the third carrying a multi-hot label
    do_reset();
    n_spk = 0;
    send(2'b01, 4'b0001, 1'b1, 1'b0);
    send(2'b10, 4'b0010, 1'b1, 1'b0);
    send(2'b11, 4'b0011, 1'b1, 1'b0);
    idle(6);
    chk("F spikes", n_spk, 3);
    chk("F w0_0", int'(dut.r_w[0][0]), 315);
    chk("F w0_1", int'(dut.r_w[0][1]), 259);
    chk("F thr0", int'(dut.r_thr[0]), 97188);
    chk("F thr1", int'(dut.r_thr[1]), 65520);
    chk_state("F");

    // Reset while two events are in flight drops both
    do_reset();
    n_spk = 0;
    send(2'b01, 4'b0001, 1'b1, 1'b0);
    send(2'b10, 4'b0001, 1'b1, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(6);
    chk("G spikes", n_spk, 0);
    chk("G w0_0", int'(dut.r_w[0][0]), 256);
    chk("G thr0", int'(dut.r_thr[0]), 65536);
    chk("G age0", int'(dut.r_age[0]), TAU);
    chk_state("G");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
